// File: rtl/i2s_pkg.sv
// Shared definitions for the stereo I2S / left-justified transmitter:
// framing-mode constants, the stereo frame container and the helper that
// picks one payload bit out of a left-aligned sample word.
package i2s_pkg;

    // Framing modes, selected by the LEFT_JUSTIFIED parameter of the top.
    localparam logic I2S_PHILIPS   = 1'b0;
    localparam logic I2S_LEFT_JUST = 1'b1;

    // Samples are stored MSB-aligned in a word of this width, so every
    // SAMPLE_W up to this value shares one frame type.
    localparam int unsigned I2S_MAX_SAMPLE_W = 32;

    typedef struct packed {
        logic [I2S_MAX_SAMPLE_W-1:0] left;
        logic [I2S_MAX_SAMPLE_W-1:0] right;
    } i2s_frame_t;

    // Payload bit k of a slot, MSB first. The sample sits MSB-aligned with
    // zeros below it, so shifting past the sample yields the zero pad bits.
    function automatic logic payload_bit(
        input logic [I2S_MAX_SAMPLE_W-1:0] aligned,
        input int unsigned                 k
    );
        logic [I2S_MAX_SAMPLE_W-1:0] shifted;
        shifted = aligned << k;
        return shifted[I2S_MAX_SAMPLE_W-1];
    endfunction

endpackage

// File: rtl/i2s_clk_gen.sv
// Bit/word clock generator. A clock-enable divider produces the BCLK phase,
// a bit counter walks the 2*SLOT_W bit periods of a frame. The "fall" strobe
// marks the clk edge where a new bit period begins; "frame_start" marks the
// fall that begins a new frame (including the first edge after enable).
module i2s_clk_gen #(
    parameter  int SLOT_W   = 32,
    parameter  int BCLK_DIV = 4,
    localparam int BIT_W    = $clog2(2 * SLOT_W)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    output logic             bclk,
    output logic             lrclk,
    output logic             fall,
    output logic             frame_start,
    output logic [BIT_W-1:0] bit_idx_next
);

    localparam int DIV_W = $clog2(BCLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST     = DIV_W'(BCLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF     = DIV_W'(BCLK_DIV / 2);
    localparam logic [BIT_W-1:0] BIT_LAST     = BIT_W'(2 * SLOT_W - 1);
    localparam logic [BIT_W-1:0] RIGHT_FIRST  = BIT_W'(SLOT_W);

    logic [DIV_W-1:0] div_cnt_r;
    logic [DIV_W-1:0] div_cnt_next_s;
    logic [BIT_W-1:0] bit_idx_r;
    logic [BIT_W-1:0] bit_idx_next_s;
    logic             running_r;
    logic             bclk_r;
    logic             lrclk_r;
    logic             fall_s;
    logic             frame_start_s;

    // Next divider / bit counter values and the fall and frame-start strobes.
    always_comb begin
        fall_s         = 1'b0;
        frame_start_s  = 1'b0;
        div_cnt_next_s = div_cnt_r;
        bit_idx_next_s = bit_idx_r;
        if (!enable) begin
            div_cnt_next_s = '0;
            bit_idx_next_s = '0;
        end else if (!running_r) begin
            // First enabled edge restarts the frame from bit 0.
            fall_s         = 1'b1;
            frame_start_s  = 1'b1;
            div_cnt_next_s = '0;
            bit_idx_next_s = '0;
        end else if (div_cnt_r == DIV_LAST) begin
            fall_s         = 1'b1;
            div_cnt_next_s = '0;
            if (bit_idx_r == BIT_LAST) begin
                frame_start_s  = 1'b1;
                bit_idx_next_s = '0;
            end else begin
                bit_idx_next_s = bit_idx_r + 1'b1;
            end
        end else begin
            div_cnt_next_s = div_cnt_r + 1'b1;
        end
    end

    // Counter state and registered bclk/lrclk derived from the next counts.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt_r <= '0;
            bit_idx_r <= '0;
            running_r <= 1'b0;
            bclk_r    <= 1'b0;
            lrclk_r   <= 1'b0;
        end else begin
            div_cnt_r <= div_cnt_next_s;
            bit_idx_r <= bit_idx_next_s;
            running_r <= enable;
            bclk_r    <= enable && (div_cnt_next_s >= DIV_HALF);
            lrclk_r   <= enable && (bit_idx_next_s >= RIGHT_FIRST);
        end
    end

    assign bclk         = bclk_r;
    assign lrclk        = lrclk_r;
    assign fall         = fall_s;
    assign frame_start  = frame_start_s;
    assign bit_idx_next = bit_idx_next_s;

endmodule

// File: rtl/i2s_tx_stereo.sv
// Stereo I2S / left-justified serial audio transmitter. One stereo frame is
// accepted per valid/ready handshake into a pending buffer, moved to the
// active buffer at each frame start, and shifted out MSB first. Missing
// frames are reported with a one-cycle underrun pulse.
module i2s_tx_stereo
    import i2s_pkg::*;
#(
    parameter int SAMPLE_W        = 16,
    parameter int SLOT_W          = 32,
    parameter int BCLK_DIV        = 4,
    parameter int LEFT_JUSTIFIED  = 0,
    parameter int UNDERRUN_REPEAT = 0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic [SAMPLE_W-1:0] sample_l,
    input  logic [SAMPLE_W-1:0] sample_r,
    input  logic                sample_valid,
    output logic                sample_ready,
    output logic                bclk,
    output logic                lrclk,
    output logic                sdata_out,
    output logic                underrun
);

    localparam int BIT_W = $clog2(2 * SLOT_W);
    localparam logic [BIT_W-1:0] RIGHT_FIRST = BIT_W'(SLOT_W);
    localparam logic FRAMING = (LEFT_JUSTIFIED != 0) ? I2S_LEFT_JUST : I2S_PHILIPS;
    localparam int unsigned ALIGN_SHIFT = I2S_MAX_SAMPLE_W - SAMPLE_W;

    logic             fall_s;
    logic             frame_start_s;
    logic [BIT_W-1:0] bit_idx_next_s;

    i2s_frame_t       pending_r;
    logic             pending_full_r;
    i2s_frame_t       active_r;
    logic             last_bit_r;
    logic             sample_ready_r;
    logic             sdata_r;
    logic             underrun_r;

    logic             accept_s;
    logic             pending_full_next_s;
    i2s_frame_t       active_next_s;
    logic             slot_right_s;
    logic [BIT_W-1:0] slot_pos_s;
    logic             lj_bit_s;

    i2s_clk_gen #(
        .SLOT_W   (SLOT_W),
        .BCLK_DIV (BCLK_DIV)
    ) u_clk_gen (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .bclk         (bclk),
        .lrclk        (lrclk),
        .fall         (fall_s),
        .frame_start  (frame_start_s),
        .bit_idx_next (bit_idx_next_s)
    );

    assign accept_s = sample_valid && sample_ready_r;

    // Buffer hand-over at frame start and pending-full bookkeeping.
    always_comb begin
        pending_full_next_s = pending_full_r;
        active_next_s       = active_r;
        if (frame_start_s) begin
            if (pending_full_r) begin
                active_next_s       = pending_r;
                pending_full_next_s = 1'b0;
            end else if (UNDERRUN_REPEAT != 0) begin
                active_next_s = active_r;
            end else begin
                active_next_s = '0;
            end
        end else begin
            active_next_s = active_r;
        end
        // An accept can only happen while pending is empty, so it never
        // collides with the hand-over above; it simply refills pending.
        if (accept_s) begin
            pending_full_next_s = 1'b1;
        end else begin
            pending_full_next_s = pending_full_next_s;
        end
    end

    // Payload bit of the bit period that begins at the coming fall.
    always_comb begin
        slot_right_s = (bit_idx_next_s >= RIGHT_FIRST);
        if (slot_right_s) begin
            slot_pos_s = bit_idx_next_s - RIGHT_FIRST;
            lj_bit_s   = payload_bit(active_next_s.right, 32'(slot_pos_s));
        end else begin
            slot_pos_s = bit_idx_next_s;
            lj_bit_s   = payload_bit(active_next_s.left, 32'(slot_pos_s));
        end
    end

    // Pending/active buffers, handshake, underrun pulse and serial data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending_r      <= '0;
            pending_full_r <= 1'b0;
            active_r       <= '0;
            last_bit_r     <= 1'b0;
            sample_ready_r <= 1'b1;
            sdata_r        <= 1'b0;
            underrun_r     <= 1'b0;
        end else begin
            if (accept_s) begin
                pending_r.left  <= I2S_MAX_SAMPLE_W'(sample_l) << ALIGN_SHIFT;
                pending_r.right <= I2S_MAX_SAMPLE_W'(sample_r) << ALIGN_SHIFT;
            end else begin
                pending_r <= pending_r;
            end
            pending_full_r <= pending_full_next_s;
            sample_ready_r <= !pending_full_next_s;
            active_r       <= active_next_s;
            underrun_r     <= frame_start_s && !pending_full_r;
            if (!enable) begin
                last_bit_r <= 1'b0;
                sdata_r    <= 1'b0;
            end else if (fall_s) begin
                // last_bit_r always holds the payload bit of the period just
                // ended, which is exactly what Philips framing sends next.
                last_bit_r <= lj_bit_s;
                sdata_r    <= (FRAMING == I2S_LEFT_JUST) ? lj_bit_s : last_bit_r;
            end else begin
                last_bit_r <= last_bit_r;
                sdata_r    <= sdata_r;
            end
        end
    end

    assign sample_ready = sample_ready_r;
    assign sdata_out    = sdata_r;
    assign underrun     = underrun_r;

endmodule
